// File: rtl/deposit_alloc_pkg.sv
// Shared definitions for the parcel-locker deposit allocator: slot
// numbering, FSM states, pickup-code LFSR polynomial and a priority helper.
package deposit_alloc_pkg;

    localparam int          NSLOT     = 8;
    localparam logic [3:0]  SLOT_NONE = 4'd8;

    localparam int          LFSR_W    = 12;
    // x^12 + x^6 + x^4 + x + 1 : feedback taps on bits 11, 5, 3, 0
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 12'h829;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_OPEN,
        ST_COMMIT
    } state_t;

    // Lowest-numbered free locker, SLOT_NONE when every locker is occupied.
    function automatic logic [3:0] first_free(input logic [NSLOT-1:0] full);
        logic [3:0] k_sel;
        k_sel = SLOT_NONE;
        for (int k = NSLOT - 1; k >= 0; k--) begin
            if (!full[k]) k_sel = 4'(k);
        end
        return k_sel;
    endfunction

endpackage

// File: rtl/pickup_code_lfsr.sv
// Free-running 12-bit Fibonacci LFSR that supplies pickup codes. Feedback
// always includes the top bit, so the state map is invertible and a
// non-zero seed can never reach the all-zero lockup state.
module pickup_code_lfsr
    import deposit_alloc_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 12'hACE
) (
    input  logic              clk_2,
    input  logic              rst,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr_q;

    // Advance one step per clock; reload the seed on reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_2) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end

    assign value = lfsr_q;

endmodule

// File: rtl/deposit_alloc.sv
// Deposit allocator: finds a free locker, blinks its door, commits a pickup
// code on door close, and answers registered pickup-code lookups.
module deposit_alloc
    import deposit_alloc_pkg::*;
#(
    parameter int                TIMEOUT = 20,
    parameter logic [LFSR_W-1:0] SEED    = 12'hACE
) (
    input  logic              clk_2,
    input  logic              rst,
    input  logic              dep_req,
    input  logic [NSLOT-1:0]  full_in,
    input  logic              door_closed,
    input  logic              cancel,
    input  logic              chk_valid,
    input  logic [LFSR_W-1:0] chk_code,
    output logic [3:0]        slot,
    output logic              busy,
    output logic [NSLOT-1:0]  door_led,
    output logic [NSLOT-1:0]  set_full,
    output logic [LFSR_W-1:0] code,
    output logic              done,
    output logic              no_space,
    output logic              timeout,
    output logic              chk_hit,
    output logic [3:0]        chk_slot
);

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t            state_q, state_next;
    logic [3:0]        slot_q;
    logic [TW-1:0]     timer_q;
    logic              blink_q;
    logic [LFSR_W-1:0] code_q;
    logic [LFSR_W-1:0] lfsr_val;
    logic [LFSR_W-1:0] table_q [NSLOT];
    logic              chk_hit_q, hit_d;
    logic [3:0]        chk_slot_q, hit_slot_d;
    logic              open_expire;

    pickup_code_lfsr #(.SEED(SEED)) u_lfsr (
        .clk_2 (clk_2),
        .rst   (rst),
        .value (lfsr_val)
    );

    assign open_expire = (timer_q == T_LAST);

    // State register.
    always_ff @(posedge clk_2) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_next;
    end

    // Next-state logic; in OPEN, cancel beats door_closed beats the timer.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state_q;
        unique case (state_q)
            ST_IDLE:   if (dep_req) state_next = ST_SEARCH;
            ST_SEARCH: state_next = (&full_in) ? ST_IDLE : ST_OPEN;
            ST_OPEN: begin
                if (cancel)           state_next = ST_IDLE;
                else if (door_closed) state_next = ST_COMMIT;
                else if (open_expire) state_next = ST_IDLE;
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Deposit datapath: slot latch, door timer, blink phase, code table.
    // slot_q stays valid through COMMIT so set_full/table can use it; the
    // visible slot output is masked outside OPEN. full_in is not re-examined
    // once a locker is held.
    // NOTE: the code table is reset explicitly because a zeroed table after
    // reset is part of the block's defined behaviour; this keeps it in flops.
    always_ff @(posedge clk_2) begin
        if (rst) begin
            slot_q  <= SLOT_NONE;
            timer_q <= '0;
            blink_q <= 1'b0;
            code_q  <= '0;
            for (int k = 0; k < NSLOT; k++) table_q[k] <= '0;
        end else begin
            unique case (state_q)
                ST_SEARCH: begin
                    slot_q  <= first_free(full_in);
                    timer_q <= '0;
                    blink_q <= !(&full_in);
                end
                ST_OPEN: begin
                    timer_q <= timer_q + 1'b1;
                    blink_q <= (state_next == ST_OPEN) ? !blink_q : 1'b0;
                    if (state_next == ST_IDLE) slot_q <= SLOT_NONE;
                end
                ST_COMMIT: begin
                    code_q                <= lfsr_val;
                    table_q[slot_q[2:0]]  <= lfsr_val;
                    slot_q                <= SLOT_NONE;
                end
                default: ;
            endcase
        end
    end

    // Lookup match against occupied lockers; lowest matching index wins.
    always_comb begin
        hit_d      = 1'b0;
        hit_slot_d = SLOT_NONE;
        for (int k = NSLOT - 1; k >= 0; k--) begin
            if (full_in[k] && (table_q[k] == chk_code)) begin
                hit_d      = 1'b1;
                hit_slot_d = 4'(k);
            end
        end
    end

    // Registered lookup result; reads the table before a same-cycle commit.
    always_ff @(posedge clk_2) begin
        if (rst) begin
            chk_hit_q  <= 1'b0;
            chk_slot_q <= SLOT_NONE;
        end else begin
            chk_hit_q  <= chk_valid && hit_d;
            chk_slot_q <= (chk_valid && hit_d) ? hit_slot_d : SLOT_NONE;
        end
    end

    // Outputs decoded from state and registers, forced to idle values in reset.
    always_comb begin
        slot     = SLOT_NONE;
        busy     = 1'b0;
        door_led = '0;
        set_full = '0;
        code     = '0;
        done     = 1'b0;
        no_space = 1'b0;
        timeout  = 1'b0;
        chk_hit  = 1'b0;
        chk_slot = SLOT_NONE;
        if (!rst) begin
            busy     = (state_q != ST_IDLE);
            code     = code_q;
            chk_hit  = chk_hit_q;
            chk_slot = chk_slot_q;
            unique case (state_q)
                ST_SEARCH: no_space = &full_in;
                ST_OPEN: begin
                    slot     = slot_q;
                    door_led = blink_q ? (NSLOT'(1) << slot_q[2:0]) : '0;
                    timeout  = open_expire && !cancel && !door_closed;
                end
                ST_COMMIT: begin
                    set_full = NSLOT'(1) << slot_q[2:0];
                    done     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_deposit_alloc.sv
// Directed self-checking bench for deposit_alloc.
module tb_deposit_alloc;

    logic        clk_2 = 1'b0;
    logic        rst, dep_req, door_closed, cancel, chk_valid;
    logic [7:0]  full_in;
    logic [11:0] chk_code;
    logic [3:0]  slot, chk_slot;
    logic        busy, done, no_space, timeout, chk_hit;
    logic [7:0]  door_led, set_full;
    logic [11:0] code;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [11:0] lfsr_m;
    logic [11:0] code1, code_c, code_r;
    logic        sf_seen;

    deposit_alloc #(.TIMEOUT(20), .SEED(12'hACE)) dut (
        .clk_2       (clk_2),
        .rst         (rst),
        .dep_req     (dep_req),
        .full_in     (full_in),
        .door_closed (door_closed),
        .cancel      (cancel),
        .chk_valid   (chk_valid),
        .chk_code    (chk_code),
        .slot        (slot),
        .busy        (busy),
        .door_led    (door_led),
        .set_full    (set_full),
        .code        (code),
        .done        (done),
        .no_space    (no_space),
        .timeout     (timeout),
        .chk_hit     (chk_hit),
        .chk_slot    (chk_slot)
    );

    always #5 clk_2 = ~clk_2;

    // Reference LFSR: x^12+x^6+x^4+x+1, shift left, feedback into bit 0.
    always @(posedge clk_2) begin
        if (rst) lfsr_m <= 12'hACE;
        else     lfsr_m <= {lfsr_m[10:0], lfsr_m[11] ^ lfsr_m[5] ^ lfsr_m[3] ^ lfsr_m[0]};
    end

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string where);
        check({where, " slot"},     16'(slot),     16'd8);
        check({where, " chk_slot"}, 16'(chk_slot), 16'd8);
        check({where, " flags"},    16'({busy, done, no_space, timeout, chk_hit}), 16'd0);
        check({where, " door_led"}, 16'(door_led), 16'h00);
        check({where, " set_full"}, 16'(set_full), 16'h00);
        check({where, " code"},     16'(code),     16'h000);
    endtask

    initial begin
        rst = 1'b1; dep_req = 1'b0; door_closed = 1'b0; cancel = 1'b0;
        chk_valid = 1'b0; chk_code = '0; full_in = 8'h00;
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;

        // Normal deposit: lowest free locker of 8'hF3 is 2.
        full_in = 8'hF3; dep_req = 1'b1;
        step();                                   // SEARCH
        dep_req = 1'b0;
        check("search busy", 16'(busy), 16'd1);
        check("search slot", 16'(slot), 16'd8);
        step();                                   // OPEN 1
        check("open1 slot", 16'(slot), 16'd2);
        check("open1 led",  16'(door_led), 16'h04);
        step();                                   // OPEN 2
        check("open2 led",  16'(door_led), 16'h00);
        step();                                   // OPEN 3
        check("open3 led",  16'(door_led), 16'h04);
        door_closed = 1'b1;
        step();                                   // COMMIT
        door_closed = 1'b0;
        code1 = lfsr_m;
        check("commit set_full", 16'(set_full), 16'h04);
        check("commit done",     16'(done),     16'd1);
        check("commit slot",     16'(slot),     16'd8);
        check("commit led",      16'(door_led), 16'h00);
        step();                                   // IDLE
        check("post set_full", 16'(set_full), 16'h00);
        check("post done",     16'(done),     16'd0);
        check("post busy",     16'(busy),     16'd0);
        check("post code",     16'(code),     16'(code1));

        // No space.
        full_in = 8'hFF; dep_req = 1'b1;
        step();                                   // SEARCH
        dep_req = 1'b0;
        check("nospace pulse", 16'(no_space), 16'd1);
        check("nospace slot",  16'(slot),     16'd8);
        step();
        check("nospace end",   16'(no_space), 16'd0);
        check("nospace busy",  16'(busy),     16'd0);

        // Timeout after 20 OPEN cycles, no commit.
        full_in = 8'h00; dep_req = 1'b1;
        step();                                   // SEARCH
        dep_req = 1'b0;
        step();                                   // OPEN 1
        sf_seen = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("timeout cyc%0d", c), 16'(timeout), (c == 20) ? 16'd1 : 16'd0);
            sf_seen = sf_seen | (|set_full);
            step();
        end
        check("timeout idle",     16'(busy),    16'd0);
        check("timeout set_full", 16'(sf_seen), 16'd0);
        check("timeout code",     16'(code),    16'(code1));

        // cancel and door_closed together: cancel wins.
        full_in = 8'h0F; dep_req = 1'b1;
        step();
        dep_req = 1'b0;
        step();                                   // OPEN 1
        check("cancel open slot", 16'(slot),     16'd4);
        check("cancel open led",  16'(door_led), 16'h10);
        cancel = 1'b1; door_closed = 1'b1;
        step();
        cancel = 1'b0; door_closed = 1'b0;
        check("cancel busy",     16'(busy),     16'd0);
        check("cancel done",     16'(done),     16'd0);
        check("cancel set_full", 16'(set_full), 16'h00);
        check("cancel slot",     16'(slot),     16'd8);
        step();
        check("cancel code", 16'(code), 16'(code1));

        // Deposit to slot 5, then lookups.
        full_in = 8'h1F; dep_req = 1'b1;
        step();
        dep_req = 1'b0;
        step();                                   // OPEN 1
        check("lk open slot", 16'(slot), 16'd5);
        door_closed = 1'b1;
        step();                                   // COMMIT
        door_closed = 1'b0;
        code_c = lfsr_m;
        check("lk set_full", 16'(set_full), 16'h20);
        full_in = 8'h3F; chk_valid = 1'b1; chk_code = code_c;
        step();                                   // lookup issued in COMMIT
        check("lk precommit hit", 16'(chk_hit), 16'd0);
        check("lk code",          16'(code),    16'(code_c));
        step();
        check("lk hit",  16'(chk_hit),  16'd1);
        check("lk slot", 16'(chk_slot), 16'd5);
        chk_code = code1;
        step();
        check("lk code1 hit",  16'(chk_hit),  16'd1);
        check("lk code1 slot", 16'(chk_slot), 16'd2);
        chk_code = code_c; full_in = 8'h1F;
        step();
        check("lk dropped hit",  16'(chk_hit),  16'd0);
        check("lk dropped slot", 16'(chk_slot), 16'd8);
        chk_valid = 1'b0; full_in = 8'h3F;
        step();
        check("lk invalid hit",  16'(chk_hit),  16'd0);
        check("lk invalid slot", 16'(chk_slot), 16'd8);

        // Reset mid-OPEN.
        full_in = 8'h00; dep_req = 1'b1;
        step();
        dep_req = 1'b0;
        step();                                   // OPEN 1
        step();                                   // OPEN 2
        check("rst pre busy", 16'(busy), 16'd1);
        rst = 1'b1; door_closed = 1'b1;
        #1;
        check_reset_vals("rst async view");
        step();
        check_reset_vals("rst sampled");
        rst = 1'b0; door_closed = 1'b0;
        step();
        check("rst after busy",     16'(busy),     16'd0);
        check("rst after set_full", 16'(set_full), 16'h00);
        check("rst after done",     16'(done),     16'd0);
        full_in = 8'hFE; dep_req = 1'b1;
        step();
        dep_req = 1'b0;
        step();                                   // OPEN 1
        check("rst dep slot", 16'(slot), 16'd0);
        door_closed = 1'b1;
        step();                                   // COMMIT
        door_closed = 1'b0;
        code_r = lfsr_m;
        step();
        check("rst dep code", 16'(code), 16'(code_r));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/deposit_alloc.md
DEPOSIT_ALLOC -- requirements
Module: deposit_alloc

Interface
REQ-001 SHALL have parameter TIMEOUT, default 20: clk_2 cycles allowed in OPEN before auto-abort.
REQ-002 SHALL have parameter SEED, default 12'hACE: non-zero LFSR reset seed.
REQ-003 SHALL have port clk_2 input 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-005 SHALL have port dep_req input 1: courier deposit request, sampled only in IDLE.
REQ-006 SHALL have port full_in input 8: locker occupancy; bit k=1 means locker k is occupied.
REQ-007 SHALL have port door_closed input 1: courier confirms the door is closed.
REQ-008 SHALL have port cancel input 1: courier aborts the deposit.
REQ-009 SHALL have ports chk_valid input 1 and chk_code input 12: pickup-code lookup request.
REQ-010 SHALL have port slot output 4: allocated locker 0..7; 4'd8 = none.
REQ-011 SHALL have port busy output 1: high in any state other than IDLE.
REQ-012 SHALL have port door_led output 8: one-hot blink on the allocated locker.
REQ-013 SHALL have port set_full output 8: one-cycle one-hot pulse marking the locker occupied.
REQ-014 SHALL have port code output 12: pickup code of the last committed deposit.
REQ-015 SHALL have ports done, no_space, timeout output 1 each: one-cycle status pulses.
REQ-016 SHALL have ports chk_hit output 1 and chk_slot output 4: lookup result.

Function
REQ-017 SHALL implement states IDLE, SEARCH, OPEN, COMMIT.
REQ-018 IDLE with dep_req=1 SHALL go to SEARCH next cycle.
- dep_req is ignored in all other states.
REQ-019 SEARCH SHALL take one cycle and select the lowest k with full_in[k]=0.
- If a free locker exists: load slot=k and go to OPEN.
- If full_in=8'hFF: pulse no_space, keep slot=8, and return to IDLE.
REQ-020 OPEN SHALL toggle door_led[slot] every cycle, starting at 1; all other bits stay 0.
- A timer clears on entry and increments once per cycle.
REQ-021 OPEN exit priority SHALL be, highest first: cancel, then door_closed, then timer reaching TIMEOUT-1.
- cancel: return to IDLE with no commit.
- door_closed: go to COMMIT.
- timer reaches TIMEOUT-1: pulse timeout and return to IDLE with no commit.
REQ-022 COMMIT SHALL take one cycle, then return to IDLE. In that cycle it:
- pulses set_full[slot];
- pulses done;
- writes the current LFSR value to code and to table[slot].
REQ-023 On every exit from OPEN, door_led SHALL be 0 and slot SHALL return to 8.
REQ-024 The 12-bit LFSR SHALL step every cycle using x^12+x^6+x^4+x+1 and never reach 0.
REQ-025 A lookup SHALL be registered, with 1-cycle latency.
- chk_hit=1 iff some k has table[k]==chk_code and full_in[k]=1; chk_slot is the lowest such k.
- Otherwise chk_hit=0 and chk_slot=8.
- When chk_valid=0, chk_hit=0.
REQ-026 A lookup issued in the COMMIT cycle SHALL see the pre-commit table.
REQ-027 If full_in[slot] rises during OPEN, it SHALL be ignored; the FSM keeps the locker.

Reset
REQ-028 While rst=1, outputs SHALL take these values:
- slot=8, chk_slot=8;
- busy, done, no_space, timeout, chk_hit = 0;
- door_led, set_full = 8'h00;
- code = 0.
REQ-029 While rst=1, state SHALL be IDLE, the timer 0, every table entry 0, and the LFSR = SEED.
REQ-030 rst asserted mid-OPEN SHALL abort with no set_full and no done pulse.

Structure
REQ-031 A shared package SHALL hold:
- NSLOT=8;
- SLOT_NONE=4'd8;
- the state enum;
- the LFSR polynomial taps.
REQ-032 The LFSR SHALL be the sub-module pickup_code_lfsr: ports clk_2, rst, and a 12-bit value output; parameter SEED.

Verification
REQ-033 Normal deposit:
- Stimulus: full_in=8'hF3, dep_req; door_closed after 3 cycles in OPEN.
- Required: slot=2, door_led toggles 8'h04/8'h00, set_full=8'h04 for one cycle, done pulses, and code matches the bench's LFSR model.
REQ-034 No space:
- Stimulus: full_in=8'hFF, dep_req.
- Required: no_space pulses 1 cycle after SEARCH; slot stays 8; busy falls next cycle.
REQ-035 Timeout with TIMEOUT=20:
- Stimulus: no door_closed.
- Required: timeout pulses on OPEN cycle 20; set_full never asserts.
REQ-036 Simultaneous exit events:
- Stimulus: cancel and door_closed in the same cycle.
- Required: return to IDLE; no done and no set_full.
REQ-037 Lookup after deposit to slot 5 with code C:
- chk_code=C gives chk_hit=1, chk_slot=5 one cycle later.
- After full_in[5] drops, the same lookup gives chk_hit=0, chk_slot=8.
REQ-038 Reset mid-OPEN:
- Stimulus: rst for 1 cycle.
- Required: all outputs return to REQ-028 values; LFSR restarts at 12'hACE.
